prbs_checker: RTL and testbench
===============================

# prbs_checker

Serial PRBS checker built on an XNOR-feedback LFSR. It sits directly downstream of the XNOR gate primitives and the matching PRBS generator. Each incoming bit is compared against a locally generated expected bit using XNOR equality. The block self-synchronises from the received stream, tracks lock, and counts bit errors for link and bench diagnostics.

## Interface
Parameters:
- LFSR_LEN, 7, LFSR length in bits; polynomial x^7+x^6+1 by default
- TAP_A, 7, first feedback tap (1-based)
- TAP_B, 6, second feedback tap (1-based)
- ERR_W, 16, error counter width
- LOSS_THRESH, 4, consecutive mismatches that force loss of lock

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- data_in, input, 1, received serial bit
- data_valid, input, 1, data_in is qualified this cycle
- err_clr, input, 1, synchronous clear of err_cnt
- locked, output, 1, checker synchronised to the stream
- err_pulse, output, 1, one-cycle flag for a mismatched bit while locked
- err_cnt, output, ERR_W, saturating count of mismatched bits
- bit_cnt, output, 32, count of checked bits; present only with PRBS_CHECKER_BITCNT_EN

## Operation
- Feedback: fb = ~(lfsr[TAP_A-1] ^ lfsr[TAP_B-1]). Shift left: lfsr <= {lfsr[LFSR_LEN-2:0], shift_in}.
- Lockup state is all-ones. All-zeros is a valid state.
- States:
  - SEED: each valid bit is shifted into lfsr as shift_in = data_in, and seed_cnt increments.
    - When seed_cnt reaches LFSR_LEN with lfsr != all-ones, go to LOCKED.
    - If the completed seed is all-ones, stay in SEED and reset seed_cnt to 0. This seed is impossible for valid XNOR PRBS data.
  - LOCKED: each valid bit compares against expected = fb, with match = ~(data_in ^ fb). The register always shifts shift_in = fb and never data_in.
    - On mismatch: err_pulse=1, err_cnt+1 (saturating at all-ones), miss_cnt+1.
    - On match: miss_cnt=0.
    - When miss_cnt reaches LOSS_THRESH, go to SEED. This clears seed_cnt and miss_cnt, but leaves err_cnt unchanged.
- Cycles with data_valid=0: no state, LFSR or counter change, and err_pulse=0.
- No errors are counted in SEED.
- err_clr clears err_cnt to 0 in any state. When err_clr coincides with a mismatch, the clear wins (err_cnt=0) and err_pulse still asserts.

## Timing
- Reset values: state SEED, lfsr all-zeros, seed_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- All outputs are registered.
- err_pulse and the err_cnt update appear the cycle after the offending valid bit.
- locked rises the cycle after the LFSR_LEN-th valid seed bit.
- locked falls the cycle after the LOSS_THRESH-th consecutive mismatch. The err_pulse for that bit asserts in the same cycle.
- The earliest lock is LFSR_LEN valid cycles after reset. The first checked bit is valid bit LFSR_LEN+1.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Deassertion is synchronised externally.

## Configuration
- PRBS_CHECKER_BITCNT_EN defined:
  - adds the bit_cnt output.
  - bit_cnt increments on every valid bit while LOCKED and wraps at 2^32.
  - err_clr also clears bit_cnt.
- PRBS_CHECKER_BITCNT_EN undefined:
  - no bit_cnt port and no counter logic.
  - all other behaviour is identical.

## Structure
- Package prbs_checker_pkg holds:
  - the state enum (SEED, LOCKED)
  - default constants for PRBS7 (LFSR_LEN=7, TAP_A=7, TAP_B=6)
  - the all-ones lockup constant function.
- Sub-module xnor_lfsr holds the LFSR register and XNOR feedback. Its interface is shift_en, shift_in, state, fb. The upstream PRBS generator reuses the same module.
- prbs_checker holds the FSM, compare and counters.

## Test plan
- Reset, then a clean PRBS7 stream from the generator seeded 0000000 (first generated bit 1): locked=1 after 7 valid bits; 1000 checked bits give err_cnt=0 and zero err_pulse.
- Locked stream with bits 100, 250 and 251 inverted: three err_pulse cycles, err_cnt=3, locked stays 1.
- Locked stream with 4 consecutive inverted bits: err_cnt=4; locked drops the cycle after bit 4; relock after 7 clean bits; err_cnt stays 4.
- Seed stream of 7 ones, then a valid PRBS: no lock after the ones; lock after the next 7 valid bits.
- data_valid toggled 50% with a clean stream: locks and remains error-free; the same stream with one bit inverted under valid gives err_cnt=1. err_clr pulsed together with a mismatch gives err_cnt=0 and err_pulse=1.
- ERR_W=4 with an inverted stream while held locked (LOSS_THRESH=32): err_cnt saturates at 15. rst_n pulsed mid-stream zeroes all outputs asynchronously. With PRBS_CHECKER_BITCNT_EN, bit_cnt=1000 after the first scenario.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared types and constants for the XNOR-feedback PRBS checker and generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   chk_state_t    - checker FSM state (SEED while acquiring, LOCKED while checking)
//   PRBS7_*        - default PRBS7 polynomial x^7+x^6+1 (length and 1-based taps)
//   lockup_state() - all-ones word of a given length; the one state an XNOR LFSR
//                    can never leave, so it can never come out of a real stream
package prbs_checker_pkg;

    typedef enum logic {
        SEED   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int PRBS7_LEN       = 7;
    localparam int PRBS7_TAP_A     = 7;
    localparam int PRBS7_TAP_B     = 6;
    localparam int DEF_ERR_W       = 16;
    localparam int DEF_LOSS_THRESH = 4;

    // Widest LFSR the lockup helper can describe.
    localparam int LFSR_MAX_LEN = 64;

    // Returns a word whose low 'len' bits are ones; callers truncate it to their
    // own LFSR width.
    function automatic logic [LFSR_MAX_LEN-1:0] lockup_state(input int len);
        logic [LFSR_MAX_LEN-1:0] v;
        v = '0;
        for (int i = 0; i < LFSR_MAX_LEN; i++) begin
            if (i < len) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/xnor_lfsr.sv
// Fibonacci LFSR with XNOR feedback, shifting left; shared by PRBS generator and checker.
// Latency: state updates one cycle after shift_en; fb is combinational from state.
// Backpressure: none; shift_en holds the register when low.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, clears the register to all-zeros
//   shift_en - shift this cycle
//   shift_in - bit entering at bit 0 (fb for free-running generation, or an
//              external bit when seeding from a received stream)
//   state    - current register contents
//   fb       - XNOR of the two taps; all-zeros is a legal state, all-ones locks up
module xnor_lfsr
    import prbs_checker_pkg::*;
#(
    parameter int LEN   = PRBS7_LEN,
    parameter int TAP_A = PRBS7_TAP_A,
    parameter int TAP_B = PRBS7_TAP_B
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift_en,
    input  logic           shift_in,
    output logic [LEN-1:0] state,
    output logic           fb
);

    logic [LEN-1:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else if (shift_en) begin
            lfsr_q <= {lfsr_q[LEN-2:0], shift_in};
        end
    end

    assign state = lfsr_q;
    assign fb    = ~(lfsr_q[TAP_A-1] ^ lfsr_q[TAP_B-1]);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds from the stream, then compares each bit to local fb.
// Latency: locked/err_pulse/err_cnt are registered, updating one cycle after the qualifying valid bit.
// Backpressure: none; data_valid=0 cycles freeze all state and force err_pulse low.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   data_in     - received serial bit, qualified by data_valid
//   data_valid  - data_in carries a bit this cycle
//   err_clr     - synchronous clear of err_cnt (and bit_cnt); wins over a same-cycle increment
//   locked      - checker is synchronised and checking
//   err_pulse   - one cycle per mismatched bit seen while locked
//   err_cnt     - saturating count of mismatched bits
//   bit_cnt     - wrapping count of bits checked while locked; exists only when
//                 PRBS_CHECKER_BITCNT_EN is defined
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int LFSR_LEN    = PRBS7_LEN,
    parameter int TAP_A       = PRBS7_TAP_A,
    parameter int TAP_B       = PRBS7_TAP_B,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int LOSS_THRESH = DEF_LOSS_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int SEED_W = $clog2(LFSR_LEN + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [LFSR_LEN-1:0] LOCKUP = LFSR_LEN'(lockup_state(LFSR_LEN));

    // ------------------------------------------------------------------
    // LFSR
    // ------------------------------------------------------------------
    logic                lfsr_shift_en;
    logic                lfsr_shift_in;
    logic [LFSR_LEN-1:0] lfsr_state;
    logic                lfsr_fb;

    xnor_lfsr #(
        .LEN   (LFSR_LEN),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (lfsr_shift_en),
        .shift_in (lfsr_shift_in),
        .state    (lfsr_state),
        .fb       (lfsr_fb)
    );

    // Register contents once the current bit has been shifted in as a seed bit;
    // the top bit falls off and is only needed by the LFSR itself.
    logic [LFSR_LEN-1:0] seed_next;
    logic                unused_lfsr_msb;
    assign seed_next       = {lfsr_state[LFSR_LEN-2:0], data_in};
    assign unused_lfsr_msb = lfsr_state[LFSR_LEN-1];

    logic match;
    assign match = ~(data_in ^ lfsr_fb);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    chk_state_t       state_q,    state_d;
    logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
    logic              err_pulse_q, err_pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            seed_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, LFSR control and counter updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        seed_cnt_d    = seed_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        err_cnt_d     = err_cnt_q;
        err_pulse_d   = 1'b0;
        lfsr_shift_en = 1'b0;
        lfsr_shift_in = data_in;

        if (data_valid) begin
            lfsr_shift_en = 1'b1;
            unique case (state_q)
                SEED: begin
                    // Received bits load the register directly. seed_cnt runs
                    // 0..LFSR_LEN-1, so the bit arriving with LFSR_LEN-1 completes
                    // the seed and the decision uses the post-shift contents.
                    lfsr_shift_in = data_in;
                    if (seed_cnt_q == SEED_W'(LFSR_LEN - 1)) begin
                        seed_cnt_d = '0;
                        // An all-ones seed cannot come from a real XNOR PRBS,
                        // and locking on it would freeze the local copy.
                        if (seed_next != LOCKUP) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end

                LOCKED: begin
                    // Free-run on local feedback so a corrupted input bit is
                    // never absorbed into the reference sequence.
                    lfsr_shift_in = lfsr_fb;
                    if (!match) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_cnt_q == MISS_W'(LOSS_THRESH - 1)) begin
                            state_d    = SEED;
                            miss_cnt_d = '0;
                            seed_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end

        // Clear has priority over a same-cycle increment; err_pulse is untouched.
        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    always_comb begin
        locked    = (state_q == LOCKED);
        err_pulse = err_pulse_q;
        err_cnt   = err_cnt_q;
    end

`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (err_clr) begin
            bit_cnt_q <= '0;
        end else if (data_valid && (state_q == LOCKED)) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: segment table + per-cycle scoreboard.
// Latency: expectations for a driven cycle are compared one clock edge later.
// Backpressure: n/a (bench).
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_in = 1'b0;
    logic        data_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked2, err_pulse2;
    logic [3:0]  err_cnt2;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0] bit_cnt, bit_cnt2;
`endif

    always #5 clk = ~clk;

    prbs_checker #(
        .LFSR_LEN(7), .TAP_A(7), .TAP_B(6), .ERR_W(16), .LOSS_THRESH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
`ifdef PRBS_CHECKER_BITCNT_EN
        ,
        .bit_cnt    (bit_cnt)
`endif
    );

    // Narrow counter, lock held through long error bursts.
    prbs_checker #(
        .LFSR_LEN(7), .TAP_A(7), .TAP_B(6), .ERR_W(4), .LOSS_THRESH(32)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clr    (err_clr),
        .locked     (locked2),
        .err_pulse  (err_pulse2),
        .err_cnt    (err_cnt2)
`ifdef PRBS_CHECKER_BITCNT_EN
        ,
        .bit_cnt    (bit_cnt2)
`endif
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // ------------------------------------------------------------------
    // Stream source: reference XNOR PRBS7 generator seeded all-zeros
    // ------------------------------------------------------------------
    logic [6:0] gen = '0;

    // ------------------------------------------------------------------
    // Behavioural expectation, written at stream level: once aligned, a bit
    // mismatches exactly when the bench inverted it.
    // ------------------------------------------------------------------
    bit         m_locked;
    logic [6:0] m_seed;
    int         m_scnt, m_miss, m_cnt;
    longint     m_bc;
    bit         sb_en = 1'b1;
    int         cyc_no = 0;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        m_locked = 1'b0; m_seed = '0; m_scnt = 0; m_miss = 0; m_cnt = 0; m_bc = 0;
        gen = '0;
        sb.delete();
    endtask

    task automatic cyc(input logic v, input logic d, input logic mis, input logic clr);
        exp_t e, got;
        e.pulse = 1'b0;
        if (v) begin
            if (!m_locked) begin
                m_seed = {m_seed[5:0], d};
                m_scnt++;
                if (m_scnt == 7) begin
                    m_scnt = 0;
                    if (m_seed != 7'h7f) m_locked = 1'b1;
                end
            end else begin
                m_bc++;
                if (mis) begin
                    e.pulse = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                    m_miss++;
                    if (m_miss == 4) begin
                        m_locked = 1'b0; m_miss = 0; m_scnt = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr) begin
            m_cnt = 0; m_bc = 0;
        end
        e.locked = m_locked;
        e.cnt    = 16'(m_cnt);
        if (sb_en) sb.push_back(e);

        data_valid = v;
        data_in    = d;
        err_clr    = clr;
        @(posedge clk);
        #1;
        cyc_no++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {locked, err_pulse, err_cnt};
            n_chk++;
            if (got == e) n_pass++;
            else $display("FAIL sb_cycle%0d: locked=%0b err_pulse=%0b err_cnt=%0d, expected locked=%0b err_pulse=%0b err_cnt=%0d",
                          cyc_no, got.locked, got.pulse, got.cnt, e.locked, e.pulse, e.cnt);
        end
    endtask

    task automatic send(input logic v, input logic inv, input logic raw1, input logic clr);
        logic d, b;
        if (v) begin
            if (raw1) begin
                d = 1'b1;
            end else begin
                b   = ~(gen[6] ^ gen[5]);
                gen = {gen[5:0], b};
                d   = b ^ inv;
            end
        end else begin
            d = 1'($urandom);
        end
        cyc(v, d, v && inv && !raw1, clr);
    endtask

    // ------------------------------------------------------------------
    // Segment table: n valid bits each, expected lock/count at segment end
    // ------------------------------------------------------------------
    typedef struct {
        string name;
        int    n;
        bit    inv;
        bit    half;
        bit    raw1;
        bit    clr;
        bit    exp_locked;
        int    exp_cnt;
    } seg_t;
    seg_t segs[$];

    function automatic void add(input string name, input int n, input bit inv, input bit half,
                                input bit raw1, input bit clr, input bit el, input int ec);
        seg_t s;
        s.name = name; s.n = n; s.inv = inv; s.half = half; s.raw1 = raw1; s.clr = clr;
        s.exp_locked = el; s.exp_cnt = ec;
        segs.push_back(s);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //   name               n     inv half raw1 clr  locked cnt
        add("lock_from_reset",  7,    0,  0,   0,   0,   1,     0);
        add("clean_1000",       1000, 0,  0,   0,   0,   1,     0);
        add("pre_err",          99,   0,  0,   0,   0,   1,     0);
        add("single_err",       1,    1,  0,   0,   0,   1,     1);
        add("gap_149",          149,  0,  0,   0,   0,   1,     1);
        add("double_err",       2,    1,  0,   0,   0,   1,     3);
        add("clean_50",         50,   0,  0,   0,   0,   1,     3);
        add("clr_vs_mismatch",  1,    1,  0,   0,   1,   1,     0);
        add("clean_5",          5,    0,  0,   0,   0,   1,     0);
        add("loss_of_lock",     4,    1,  0,   0,   0,   0,     4);
        add("relock",           7,    0,  0,   0,   0,   1,     4);
        add("clean_20",         20,   0,  0,   0,   0,   1,     4);
        add("loss_again",       4,    1,  0,   0,   0,   0,     8);
        add("ones_seed",        7,    0,  0,   1,   0,   0,     8);
        add("lock_after_ones",  7,    0,  0,   0,   0,   1,     8);
        add("clear",            1,    0,  0,   0,   1,   1,     0);
        add("half_valid_clean", 200,  0,  1,   0,   0,   1,     0);
        add("half_valid_err",   1,    1,  1,   0,   0,   1,     1);
        add("half_valid_tail",  30,   0,  1,   0,   0,   1,     1);

        // Reset state
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked",    locked,    0);
        check("reset_err_pulse", err_pulse, 0);
        check("reset_err_cnt",   err_cnt,   0);
`ifdef PRBS_CHECKER_BITCNT_EN
        check("reset_bit_cnt",   bit_cnt,   0);
`endif
        rst_n = 1'b1;

        // Idle cycles must not advance anything
        repeat (3) send(1'b0, 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < segs.size(); s++) begin
            for (int i = 0; i < segs[s].n; i++) begin
                send(1'b1, segs[s].inv, segs[s].raw1, segs[s].clr && (i == segs[s].n - 1));
                if (segs[s].half) send(1'b0, 1'b0, 1'b0, 1'b0);
            end
            check({segs[s].name, "_locked"},  locked,  segs[s].exp_locked);
            check({segs[s].name, "_err_cnt"}, err_cnt, segs[s].exp_cnt);
`ifdef PRBS_CHECKER_BITCNT_EN
            if (s == 1) check("bit_cnt_1000", bit_cnt, 1000);
`endif
        end

        // Asynchronous reset mid-stream: outputs clear before any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_locked",     locked,   0);
        check("async_rst_err_cnt",    err_cnt,  0);
        check("async_rst_err_pulse",  err_pulse, 0);
        check("async_rst_sat_cnt",    err_cnt2, 0);
        check("async_rst_sat_locked", locked2,  0);
`ifdef PRBS_CHECKER_BITCNT_EN
        check("async_rst_bit_cnt",    bit_cnt,  0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Saturation on the narrow counter while lock is held
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_locked_start", locked2, 1);
        sb_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 0)  check("sat_cnt_1",  err_cnt2, 1);
            if (i == 14) check("sat_cnt_15", err_cnt2, 15);
        end
        check("sat_cnt_held",   err_cnt2,   15);
        check("sat_pulse_held", err_pulse2, 1);
        check("sat_locked_end", locked2,    1);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_idle_pulse", err_pulse2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
